// File: rtl/rv_bus_pkg.sv
// Shared types for the I/D memory bus arbiter: FSM states, owner encoding
// and the round-robin winner pick.
package rv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // On a tie the requester that did not own the bus last goes first.
    function automatic owner_t rr_pick(input logic a_i, input logic a_d, input owner_t last);
        if (a_i && a_d) return (last == OWN_I) ? OWN_D : OWN_I;
        return a_d ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Progress watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES = 0 disables it.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !w_hit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign w_hit = 1'b0;
        end else begin : g_on
            assign w_hit = (r_cnt == CNT_W'(LIMIT));
        end
    endgenerate

    assign expired = enable && w_hit;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port memory between instruction fetch (I) and
// load/store (D), one outstanding transaction at a time, with a stall watchdog.
module mem_bus_arbiter
    import rv_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t          r_state;
    owner_t              r_owner;
    owner_t              r_last;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_i_rvalid, r_i_err, r_d_rvalid, r_d_err;
    logic [DATA_W-1:0]   r_i_rdata, r_d_rdata;

    owner_t              w_win;
    logic                w_start, w_accept, w_done, w_busy;
    logic                w_expired, w_timeout, w_rsp_fire, w_clear;
    logic [DATA_W-1:0]   w_rsp_data;

    assign w_win    = rr_pick(i_req, d_req, r_last);
    // Gated by rst so no grant can leak out while reset is asserted.
    assign w_start  = (r_state == IDLE) && (i_req || d_req) && !rst;
    assign w_accept = (r_state == REQ)  && m_gnt;
    assign w_done   = (r_state == RESP) && m_rvalid;
    assign w_busy   = (r_state == REQ)  || (r_state == RESP);

    // Real progress in the same cycle as expiry wins over the timeout.
    assign w_timeout  = w_expired && !w_accept && !w_done;
    assign w_rsp_fire = w_done || w_timeout;
    assign w_rsp_data = (w_timeout || r_we) ? '0 : m_rdata;
    assign w_clear    = w_start || w_accept || w_rsp_fire;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .enable  (w_busy),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_D;
            r_last     <= OWN_D;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_i_rvalid <= 1'b0;
            r_i_err    <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_i_err    <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= '0;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_owner <= w_win;
                        r_state <= REQ;
                        if (w_win == OWN_I) begin
                            r_we    <= 1'b0;
                            r_addr  <= i_addr;
                            r_wdata <= '0;
                            r_wstrb <= '0;
                        end else begin
                            r_we    <= d_we;
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_wstrb <= d_wstrb;
                        end
                    end
                end
                REQ: begin
                    if (w_accept) r_state <= RESP;
                end
                RESP: ;
                default: r_state <= IDLE;
            endcase

            if (w_rsp_fire) begin
                r_state <= IDLE;
                r_last  <= r_owner;
                if (r_owner == OWN_I) begin
                    r_i_rvalid <= 1'b1;
                    r_i_err    <= w_timeout;
                    r_i_rdata  <= w_rsp_data;
                end else begin
                    r_d_rvalid <= 1'b1;
                    r_d_err    <= w_timeout;
                    r_d_rdata  <= w_rsp_data;
                end
            end
        end
    end

    assign i_gnt    = w_start && (w_win == OWN_I);
    assign d_gnt    = w_start && (w_win == OWN_D);
    assign i_rvalid = r_i_rvalid;
    assign i_err    = r_i_err;
    assign i_rdata  = r_i_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_err    = r_d_err;
    assign d_rdata  = r_d_rdata;

    assign m_req   = (r_state == REQ);
    assign m_we    = r_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign m_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model checked every
// cycle, a small memory responder, and directed scenarios with literal checks.
module tb_mem_bus_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} txn_t;
    typedef struct {int cyc; bit is_d;} gev_t;
    typedef struct {int cyc; bit is_d; logic [31:0] data; logic err;} rev_t;
    typedef struct {int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} mev_t;

    logic [31:0] iq[$];
    txn_t        dq[$];
    gev_t        glog[$];
    rev_t        rlog[$];
    mev_t        mlog[$];
    int          mreq_cycles;
    bit          m_req_q;

    // Reference model: is a transaction in flight, has memory accepted it,
    // who owns it, and the cycle its current phase began.
    bit          busy, acc, own_d, last_d;
    txn_t        txn;
    int          t_mark, cyc;
    bit          e_rv_i, e_rv_d, e_err;
    logic [31:0] e_rdata;
    bit          p_i, p_d;

    logic [31:0] mem [logic [31:0]];
    int          gnt_dly, rsp_dly, wait_cnt;
    bit          stall, inject_rv, mem_busy;
    logic [31:0] mem_rd;

    int errors, checks;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic mem_drive();
        logic [31:0] w;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        if (rst) begin
            mem_busy = 1'b0; wait_cnt = 0; inject_rv = 1'b0;
        end else if (inject_rv) begin
            m_rvalid = 1'b1; m_rdata = 32'hBAD0_0BAD; inject_rv = 1'b0;
        end else if (mem_busy) begin
            if (wait_cnt >= rsp_dly) begin
                m_rvalid = 1'b1; m_rdata = mem_rd; mem_busy = 1'b0; wait_cnt = 0;
            end else wait_cnt++;
        end else if (m_req && !stall) begin
            if (wait_cnt >= gnt_dly) begin
                m_gnt = 1'b1; mem_busy = 1'b1; wait_cnt = 0;
                if (m_we) begin
                    w = mem_peek(m_addr);
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                    mem[m_addr] = w;
                    mem_rd = 32'hDEAD_BEEF;
                end else mem_rd = mem_peek(m_addr);
            end else wait_cnt++;
        end else wait_cnt = 0;
    endtask

    task automatic complete(input bit err, input logic [31:0] data);
        e_rv_i = !own_d; e_rv_d = own_d; e_err = err; e_rdata = data;
        busy = 1'b0; last_d = own_d;
    endtask

    task automatic check_and_model();
        bit eig, edg, mexp;
        p_i = 1'b0; p_d = 1'b0;
        if (i_gnt) glog.push_back('{cyc, 1'b0});
        if (d_gnt) glog.push_back('{cyc, 1'b1});
        if (i_rvalid) rlog.push_back('{cyc, 1'b0, i_rdata, i_err});
        if (d_rvalid) rlog.push_back('{cyc, 1'b1, d_rdata, d_err});
        if (m_req) begin
            mreq_cycles++;
            if (!m_req_q) mlog.push_back('{cyc, m_we, m_addr, m_wdata, m_wstrb});
        end
        m_req_q = m_req;
        if (rst) begin
            chk("rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
            chk("rst_rsp", {28'd0, i_rvalid, d_rvalid, i_err, d_err}, 32'd0);
            chk("rst_rdata", i_rdata | d_rdata, 32'd0);
            chk("rst_mreq", {26'd0, m_req, m_we, m_wstrb}, 32'd0);
            chk("rst_mfields", m_addr | m_wdata, 32'd0);
            busy = 1'b0; last_d = 1'b1;
            e_rv_i = 1'b0; e_rv_d = 1'b0; e_err = 1'b0; e_rdata = '0;
            return;
        end
        eig  = !busy && i_req && (!d_req || last_d);
        edg  = !busy && d_req && !eig;
        mexp = busy && !acc;
        chk("i_gnt", i_gnt, eig);
        chk("d_gnt", d_gnt, edg);
        chk("m_req", m_req, mexp);
        if (mexp) begin
            chk("m_addr", m_addr, txn.addr);
            chk("m_we", m_we, txn.we);
            chk("m_wdata", m_wdata, txn.wdata);
            chk("m_wstrb", m_wstrb, txn.wstrb);
        end
        chk("i_rvalid", i_rvalid, e_rv_i);
        chk("d_rvalid", d_rvalid, e_rv_d);
        chk("i_err", i_err, e_rv_i & e_err);
        chk("d_err", d_err, e_rv_d & e_err);
        if (e_rv_i) chk("i_rdata", i_rdata, e_rdata);
        if (e_rv_d) chk("d_rdata", d_rdata, e_rdata);

        e_rv_i = 1'b0; e_rv_d = 1'b0; e_err = 1'b0; e_rdata = '0;
        p_i = eig; p_d = edg;
        if (eig || edg) begin
            busy = 1'b1; acc = 1'b0; own_d = edg; t_mark = cyc + 1;
            txn = eig ? '{1'b0, i_addr, 32'h0, 4'h0} : '{d_we, d_addr, d_wdata, d_wstrb};
        end else if (busy) begin
            if (!acc && m_gnt) begin
                acc = 1'b1; t_mark = cyc + 1;
            end else if (acc && m_rvalid) complete(1'b0, txn.we ? 32'h0 : m_rdata);
            else if (cyc - t_mark + 1 == TO) complete(1'b1, 32'h0);
        end
    endtask

    task automatic update_drivers();
        if (p_i && iq.size() != 0) void'(iq.pop_front());
        if (p_d && dq.size() != 0) void'(dq.pop_front());
        p_i = 1'b0; p_d = 1'b0;
        i_req  = iq.size() != 0;
        i_addr = i_req ? iq[0] : 32'h0;
        d_req  = dq.size() != 0;
        if (d_req) {d_we, d_addr, d_wdata, d_wstrb} = dq[0];
        else {d_we, d_addr, d_wdata, d_wstrb} = '0;
    endtask

    task automatic cycle();
        @(negedge clk);
        mem_drive();
        #1;
        check_and_model();
        @(posedge clk);
        #1;
        cyc++;
        update_drivers();
    endtask

    task automatic drain(input string nm, input int max);
        int n;
        bit done;
        n = 0;
        while ((iq.size() != 0 || dq.size() != 0 || busy || e_rv_i || e_rv_d) && n < max) begin
            cycle();
            n++;
        end
        done = !(iq.size() != 0 || dq.size() != 0 || busy || e_rv_i || e_rv_d);
        chk({nm, "_drained"}, done, 1);
    endtask

    task automatic clear_logs();
        glog.delete(); rlog.delete(); mlog.delete(); mreq_cycles = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        iq.delete(); dq.delete(); update_drivers();
        repeat (n) cycle();
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        bit ok;
        int n;
        errors = 0; checks = 0; cyc = 0; last_d = 1'b1; busy = 1'b0; acc = 1'b0;
        gnt_dly = 0; rsp_dly = 0; stall = 1'b0; inject_rv = 1'b0; mem_busy = 1'b0;
        wait_cnt = 0; m_req_q = 1'b0; mreq_cycles = 0; p_i = 1'b0; p_d = 1'b0;
        mem[32'h80] = 32'h3E80_0093;
        @(posedge clk); #1;
        do_reset(3);

        // 1: single fetch, minimum latency
        iq.push_back(32'h80); update_drivers();
        drain("t1", 20);
        chk("t1_counts", {glog.size() == 1, rlog.size() == 1, mlog.size() == 1}, 3'b111);
        if (glog.size() == 1 && rlog.size() == 1 && mlog.size() == 1) begin
            chk("t1_owner", glog[0].is_d, 0);
            chk("t1_mreq_lat", mlog[0].cyc - glog[0].cyc, 1);
            chk("t1_maddr", mlog[0].addr, 32'h80);
            chk("t1_rsp_lat", rlog[0].cyc - glog[0].cyc, 3);
            chk("t1_rdata", rlog[0].data, 32'h3E80_0093);
            chk("t1_err", rlog[0].err, 0);
        end

        // 2: tie after reset goes to I, then the D store
        do_reset(2);
        iq.push_back(32'h100);
        dq.push_back('{1'b1, 32'h8, 32'h3FE, 4'hF});
        update_drivers();
        drain("t2", 30);
        chk("t2_counts", {glog.size() == 2, rlog.size() == 2, mlog.size() == 2}, 3'b111);
        if (glog.size() == 2 && rlog.size() == 2 && mlog.size() == 2) begin
            chk("t2_order", {glog[0].is_d, glog[1].is_d}, 2'b01);
            chk("t2_mwe", mlog[1].we, 1);
            chk("t2_maddr", mlog[1].addr, 32'h8);
            chk("t2_mwdata", mlog[1].wdata, 32'h3FE);
            chk("t2_mwstrb", mlog[1].wstrb, 4'hF);
            chk("t2_d_rsp", {rlog[1].is_d, rlog[1].err}, 2'b10);
            chk("t2_d_rdata", rlog[1].data, 32'h0);
        end

        // 3: both held for four transactions, slower memory
        clear_logs();
        gnt_dly = 2; rsp_dly = 1;
        iq.push_back(32'h84); iq.push_back(32'h88);
        dq.push_back('{1'b0, 32'h8, 32'h0, 4'h0});
        dq.push_back('{1'b1, 32'hC, 32'h1122_3344, 4'b0101});
        update_drivers();
        drain("t3", 60);
        chk("t3_counts", {glog.size() == 4, rlog.size() == 4}, 2'b11);
        if (glog.size() == 4 && rlog.size() == 4) begin
            chk("t3_order", {glog[0].is_d, glog[1].is_d, glog[2].is_d, glog[3].is_d}, 4'b0101);
            ok = 1'b1;
            for (int k = 0; k < 3; k++) if (glog[k+1].cyc < rlog[k].cyc) ok = 1'b0;
            chk("t3_one_outstanding", ok, 1);
            chk("t3_load_data", rlog[1].data, 32'h0000_03FE);
            chk("t3_store_data", rlog[3].data, 32'h0);
        end

        // 4: memory never grants -> timeout, late m_rvalid ignored
        clear_logs();
        gnt_dly = 0; rsp_dly = 0; stall = 1'b1;
        dq.push_back('{1'b0, 32'h40, 32'h0, 4'h0}); update_drivers();
        drain("t4", 30);
        stall = 1'b0;
        inject_rv = 1'b1;
        repeat (4) cycle();
        chk("t4_counts", {glog.size() == 1, rlog.size() == 1}, 2'b11);
        if (glog.size() == 1 && rlog.size() == 1) begin
            chk("t4_rsp_lat", rlog[0].cyc - glog[0].cyc, TO + 1);
            chk("t4_mreq_cycles", mreq_cycles, TO);
            chk("t4_rsp", {rlog[0].is_d, rlog[0].err}, 2'b11);
            chk("t4_rdata", rlog[0].data, 32'h0);
        end
        iq.push_back(32'h80); update_drivers();
        drain("t4b", 20);
        chk("t4_recover", (rlog.size() == 2) ? rlog[1].data : 32'hFFFF_FFFF, 32'h3E80_0093);

        // 4c: timeout while waiting in RESP; the late response is ignored
        clear_logs();
        rsp_dly = 12;
        iq.push_back(32'h90); update_drivers();
        drain("t4c", 30);
        repeat (8) cycle();
        chk("t4c_count", rlog.size(), 1);
        if (rlog.size() == 1 && glog.size() == 1) begin
            chk("t4c_rsp_lat", rlog[0].cyc - glog[0].cyc, TO + 2);
            chk("t4c_err", rlog[0].err, 1);
        end

        // 5: reset while in RESP
        rsp_dly = 5;
        do_reset(2);
        iq.push_back(32'h80); update_drivers();
        n = 0;
        while (!(busy && acc) && n < 10) begin cycle(); n++; end
        chk("t5_reach_resp", busy && acc, 1);
        cycle();
        dq.push_back('{1'b0, 32'h44, 32'h0, 4'h0}); update_drivers();
        clear_logs();
        rst = 1'b1;
        #1;
        chk("t5_async_mreq", {m_req, m_we}, 2'b00);
        chk("t5_async_maddr", m_addr, 32'h0);
        chk("t5_async_gnt", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 4'h0);
        rsp_dly = 0;
        repeat (3) cycle();
        iq.push_back(32'h88); update_drivers();
        rst = 1'b0;
        drain("t5", 40);
        chk("t5_counts", {glog.size() == 2, rlog.size() == 2}, 2'b11);
        if (glog.size() == 2 && rlog.size() == 2) begin
            chk("t5_first_tie", glog[0].is_d, 0);
            chk("t5_first_rsp", {rlog[0].is_d, rlog[0].err}, 2'b00);
            chk("t5_first_data", rlog[0].data, 32'hA5A5_0088);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
